fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch front end for the ARM core.
- Holds the fetch PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO and presents them, with their PC, to the controller/datapath.
- Consumes the controller's PCSrc redirect and branch target to flush in-flight and buffered instructions.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-low reset
imem_req  output  1  instruction memory request valid
imem_addr  output  32  word-aligned fetch address
imem_ack  input  1  memory accepts request and returns imem_rdata this cycle
imem_rdata  input  32  fetched instruction word, valid when imem_ack=1
instr  output  32  head instruction (feeds controller Instr[31:12] and datapath)
instr_valid  output  1  head entry valid
instr_ready  input  1  core consumes head this cycle
instr_pc  output  32  address of head instruction
instr_pc8  output  32  instr_pc+8 (ARM architectural PC read value)
PCSrc  input  1  redirect strobe from controller
branch_target  input  32  redirect address; bits [1:0] ignored, forced to 00

Behaviour:
- Reset (reset=0 at a clock edge): fetch_pc=RESET_PC; FIFO empty; discard=0; FSM=IDLE; imem_req=0; instr_valid=0; instr=0; instr_pc=0; instr_pc8=8.
- FSM states: IDLE, REQ.
  - IDLE -> REQ when FIFO has a free slot, counting one slot reserved per outstanding request.
  - REQ: imem_req=1 and imem_addr=fetch_pc, held stable until imem_ack.
  - On ack: fetch_pc += 4, wrapping 32'hFFFF_FFFC -> 0.
  - After ack: stay in REQ if a slot is still free, else go to IDLE.
- Handshake:
  - imem_addr must not change while imem_req=1 and imem_ack=0.
  - At most one outstanding request.
  - Combinational single-cycle ack (imem_ack in the same cycle req rises) is legal.
- Push: on imem_ack with discard=0, write {fetch_pc, imem_rdata} at the FIFO tail.
- Pop: on instr_valid & instr_ready, advance the head.
  - Simultaneous push and pop on a full FIFO is not possible, because of slot reservation.
  - Simultaneous push and pop on a non-empty FIFO keeps the count unchanged.
- Latency: with an empty FIFO, instr_valid rises the cycle after imem_ack. No combinational path from imem_rdata to instr.
- Redirect: PCSrc=1 at an edge (wins over all other events that cycle):
  - FIFO flushed; any pop that cycle is ignored.
  - fetch_pc = {branch_target[31:2],2'b00}.
  - If in REQ and imem_ack=0, the request stays held with its old address and discard=1. The matching ack is dropped and clears discard. The next request uses the target.
  - If in REQ and imem_ack=1, the returned word is dropped and the next request uses the target.
  - If IDLE, the next cycle enters REQ with the target.
- PCSrc with instr_valid=0 is legal and behaves the same way.
- FIFO pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit.
- instr_ready while instr_valid=0 has no effect.

Optional Feature:
- FETCH_PERF_EN defined:
  - Adds outputs perf_fetched[31:0], incremented on each push.
  - Adds perf_flushed[31:0], incremented by the number of entries discarded per redirect, plus 1 per dropped in-flight word.
  - Both counters are cleared by reset and wrap at 2^32.
- FETCH_PERF_EN undefined: neither port nor counter logic exists.

Test Plan:
- Reset release, memory acks every request next cycle, instr_ready=1:
  - imem_addr sequence 0,4,8,C.
  - instr_pc follows one cycle behind the data.
  - instr_pc8 = instr_pc+8.
- instr_ready=0 with DEPTH=2:
  - Exactly two acks accepted, then imem_req=0.
  - Raise ready: head pops in order and req reasserts.
- PCSrc=1, branch_target=32'h0000_0103, while a request at 8 is pending without ack:
  - Addr 8 is held until ack and its data is dropped.
  - Next imem_addr=32'h0000_0100; FIFO empty meanwhile.
- PCSrc coincident with imem_ack and instr_ready, FIFO holding 2 entries:
  - All dropped; instr_valid=0 next cycle.
  - Next fetch at target; (with FETCH_PERF_EN) perf_flushed increases by 3.
- RESET_PC=32'hFFFF_FFF8, continuous acks: addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset=0 mid-request with the FIFO partly full:
  - Next cycle imem_req=0, instr_valid=0.
  - After release, first imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: fetch PC, req/ack instruction memory port, PC-tagged FIFO, PCSrc redirect.
// Define FETCH_PERF_EN to add the perf_fetched / perf_flushed counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pc8,
    input  logic        PCSrc,
    input  logic [31:0] branch_target
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

    typedef enum logic {IDLE, REQ} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] hold_addr;
    logic        discard;
    logic [PW:0] wr_ptr, rd_ptr, count, count_nxt;
    logic [31:0] buf_data [DEPTH];
    logic [31:0] buf_pc   [DEPTH];
    logic        acked, push, pop;
    logic        unused_bits;

    assign unused_bits = ^branch_target[1:0];

    assign count       = wr_ptr - rd_ptr;
    assign instr_valid = (count != '0);
    assign acked       = (state == REQ) && imem_ack;
    assign push        = acked && !discard && !PCSrc;
    assign pop         = instr_valid && instr_ready && !PCSrc;

    assign imem_req    = (state == REQ);
    // A redirect under a pending request parks the old address so the bus stays stable.
    assign imem_addr   = discard ? hold_addr : fetch_pc;

    assign instr       = instr_valid ? buf_data[rd_ptr[PW-1:0]] : '0;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr[PW-1:0]]   : '0;
    assign instr_pc8   = instr_pc + 32'd8;

    // The outstanding request owns a slot, so a new request starts only if one is free.
    always_comb begin
        count_nxt = count;
        state_nxt = state;
        if (PCSrc)
            count_nxt = '0;
        else
            count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        if (state == REQ && !imem_ack)
            state_nxt = REQ;
        else if (count_nxt < DEPTH_C)
            state_nxt = REQ;
        else
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            hold_addr <= '0;
            discard   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state <= state_nxt;
            if (PCSrc) begin
                fetch_pc <= {branch_target[31:2], 2'b00};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                if (state == REQ && !imem_ack) begin
                    discard <= 1'b1;
                    if (!discard)
                        hold_addr <= fetch_pc;
                end else begin
                    discard <= 1'b0;
                end
            end else begin
                if (acked) begin
                    discard <= 1'b0;
                    if (!discard)
                        fetch_pc <= fetch_pc + 32'd4;
                end
                if (push)
                    wr_ptr <= wr_ptr + (PW+1)'(1);
                if (pop)
                    rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr[PW-1:0]] <= imem_rdata;
            buf_pc[wr_ptr[PW-1:0]]   <= fetch_pc;
        end
    end

`ifdef FETCH_PERF_EN
    logic drop;
    assign drop = acked && (discard || PCSrc);

    // Flush cost: buffered entries thrown away plus any returned word that is dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push)
                perf_fetched <= perf_fetched + 32'd1;
            if (PCSrc || drop)
                perf_flushed <= perf_flushed + (PCSrc ? 32'(count) : 32'd0)
                                             + (drop  ? 32'd1      : 32'd0);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed tables, redirect/reset corner sequences and a random stream model.
module tb_fetch_unit;
    logic clk;
    logic reset;

    // DEPTH=2, RESET_PC=0 instance
    logic        req, ack, valid, ready, pcsrc;
    logic [31:0] addr, rdata, instr, pc, pc8, target;
    // DEPTH=4, RESET_PC=FFFF_FFF8 instance
    logic        b_req, b_ack, b_valid, b_ready, b_pcsrc;
    logic [31:0] b_addr, b_rdata, b_instr, b_pc, b_pc8, b_target;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_f, perf_x, b_perf_f, b_perf_x;
`endif

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    assign rdata   = mem(addr);
    assign b_rdata = mem(b_addr);

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_dut (
        .clk(clk), .reset(reset),
        .imem_req(req), .imem_addr(addr), .imem_ack(ack), .imem_rdata(rdata),
        .instr(instr), .instr_valid(valid), .instr_ready(ready),
        .instr_pc(pc), .instr_pc8(pc8),
        .PCSrc(pcsrc), .branch_target(target)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_f), .perf_flushed(perf_x)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset),
        .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack), .imem_rdata(b_rdata),
        .instr(b_instr), .instr_valid(b_valid), .instr_ready(b_ready),
        .instr_pc(b_pc), .instr_pc8(b_pc8),
        .PCSrc(b_pcsrc), .branch_target(b_target)
`ifdef FETCH_PERF_EN
        , .perf_fetched(b_perf_f), .perf_flushed(b_perf_x)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ack;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[9];

    // DEPTH=4 instance: address wrap and a redirect that hits a 2-entry FIFO plus an ack.
    initial begin
        b_ack = 0; b_ready = 0; b_pcsrc = 0; b_target = 0;
        @(posedge reset);
        b_ack = 1; b_ready = 0;
        @(negedge clk);
        chk("wrap_req0", {31'd0, b_req}, 1);
        chk("wrap_addr0", b_addr, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("wrap_addr1", b_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_addr2", b_addr, 32'h0000_0000);
        chk("wrap_valid", {31'd0, b_valid}, 1);
        chk("wrap_pc", b_pc, 32'hFFFF_FFF8);
        chk("wrap_pc8", b_pc8, 32'h0000_0000);
`ifdef FETCH_PERF_EN
        chk("perf_fetched", b_perf_f, 2);
`endif
        b_pcsrc = 1; b_target = 32'h0000_0203; b_ready = 1; b_ack = 1;
        @(negedge clk);
        chk("flush3_valid", {31'd0, b_valid}, 0);
        chk("flush3_req", {31'd0, b_req}, 1);
        chk("flush3_addr", b_addr, 32'h0000_0200);
`ifdef FETCH_PERF_EN
        chk("perf_flushed", b_perf_x, 3);
        chk("perf_fetched2", b_perf_f, 2);
`endif
        b_pcsrc = 0; b_ack = 1;
        @(negedge clk);
        chk("flush3_tgt_pc", b_pc, 32'h0000_0200);
        chk("flush3_tgt_instr", b_instr, mem(32'h0000_0200));
        b_ack = 0;
    end

    initial begin
        int acks;
        int consumed;
        logic        hold_v;
        logic [31:0] hold_a, exp_pc;
        logic        r_ready, r_pcsrc, r_ack;
        logic [31:0] r_tgt;

        //           ack   ready req   addr          valid pc
        tbl[0] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0004, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h4};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_0008, 1'b0, 32'h0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h8};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h0000_000C, 1'b0, 32'h0};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 32'h0000_0010, 1'b1, 32'hC};

        reset = 0; ack = 0; ready = 0; pcsrc = 0; target = 0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, req}, 0);
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", pc, 0);
        chk("rst_pc8", pc8, 8);
        chk("rst_b_req", {31'd0, b_req}, 0);
        reset = 1; ack = 0; ready = 1;

        // acks arrive one cycle after each request, ready held high
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_req", i), {31'd0, req}, {31'd0, tbl[i].req});
            chk($sformatf("tbl%0d_addr", i), addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].valid});
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("tbl%0d_pc8", i), pc8, tbl[i].pc + 32'd8);
            chk($sformatf("tbl%0d_instr", i), instr, tbl[i].valid ? mem(tbl[i].pc) : 32'h0);
            ack = tbl[i].ack; ready = tbl[i].ready;
        end

        // back-pressure: only DEPTH acks may be taken
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ready = 0;
            ack = req;
            if (req) acks++;
        end
        chk("bp_acks", acks, 2);
        chk("bp_req", {31'd0, req}, 0);
        chk("bp_valid", {31'd0, valid}, 1);
        chk("bp_pc", pc, 32'h10);
        ack = 0; ready = 1;
        @(negedge clk);
        chk("bp_pop_pc", pc, 32'h14);
        chk("bp_pop_instr", instr, mem(32'h14));
        chk("bp_req_again", {31'd0, req}, 1);
        chk("bp_addr_again", addr, 32'h18);
        @(negedge clk);
        chk("bp_empty", {31'd0, valid}, 0);

        // redirect while a request is pending without ack
        hold_a = addr;
        pcsrc = 1; target = 32'h0000_0103; ack = 0;
        @(negedge clk);
        pcsrc = 0;
        chk("rd_hold_req", {31'd0, req}, 1);
        chk("rd_hold_addr", addr, hold_a);
        chk("rd_hold_valid", {31'd0, valid}, 0);
        @(negedge clk);
        chk("rd_hold_addr2", addr, hold_a);
        ack = 1;
        @(negedge clk);
        chk("rd_drop_valid", {31'd0, valid}, 0);
        chk("rd_tgt_addr", addr, 32'h0000_0100);
        chk("rd_tgt_req", {31'd0, req}, 1);
        @(negedge clk);
        chk("rd_tgt_pc", pc, 32'h0000_0100);
        chk("rd_tgt_instr", instr, mem(32'h0000_0100));
        ack = 0; ready = 0;

        // reset mid-request with one entry buffered
        reset = 0;
        @(negedge clk);
        chk("mrst_req", {31'd0, req}, 0);
        chk("mrst_valid", {31'd0, valid}, 0);
        chk("mrst_pc8", pc8, 8);
        reset = 1;
        @(negedge clk);
        chk("mrst_req2", {31'd0, req}, 1);
        chk("mrst_addr", addr, 32'h0);

        // random traffic: delivered stream must run sequentially from the last redirect
        exp_pc = 32'h0; hold_v = 0; hold_a = 0; consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold_v) begin
                chk("rnd_hold_req", {31'd0, req}, 1);
                chk("rnd_hold_addr", addr, hold_a);
            end
            r_ready = ($urandom % 4) != 0;
            r_pcsrc = ($urandom % 20) == 0;
            r_tgt   = $urandom;
            r_ack   = req && ($urandom % 2 == 1);
            if (valid && r_ready && !r_pcsrc) begin
                chk("rnd_pc", pc, exp_pc);
                chk("rnd_pc8", pc8, exp_pc + 32'd8);
                chk("rnd_instr", instr, mem(exp_pc));
                exp_pc += 32'd4;
                consumed++;
            end
            if (r_pcsrc) exp_pc = {r_tgt[31:2], 2'b00};
            hold_v = req && !r_ack;
            hold_a = addr;
            ready = r_ready; pcsrc = r_pcsrc; target = r_tgt; ack = r_ack;
            @(negedge clk);
        end
        chk("rnd_progress", {31'd0, consumed > 200}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
